// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner
// encoding and the width of the fetch starvation counter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_CNT_W = 4;

  // Data wins unless fetch is the only contender or fetch has been starved.
  function automatic owner_t arbitrate(input logic i_ok, input logic d_ok,
                                       input logic starved);
    if (!i_ok) return OWN_D;
    if (d_ok && !starved) return OWN_D;
    return OWN_I;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating, clearable count of cycles a fetch has waited; flags when the
// count has reached the starvation limit.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [STARVE_CNT_W-1:0] LIM_C   = STARVE_CNT_W'(LIM);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt >= LIM_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data has priority; a starved fetch wins; a branch flush cancels the fetch.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_flush,
  output logic            i_valid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  state_t state;
  logic   flush_pend;
  logic   starved;
  logic   i_ok;
  logic   d_ok;
  logic   grant;
  owner_t grant_own;
  logic   grant_i;
  logic   starve_inc;
  logic   starve_clr;

  // A requester is ignored in the cycle its own response is presented.
  assign i_ok      = i_req && !i_flush && !i_valid;
  assign d_ok      = d_req && !d_valid;
  assign grant     = (state == IDLE) && (i_ok || d_ok);
  assign grant_own = arbitrate(i_ok, d_ok, starved);
  assign grant_i   = grant && (grant_own == OWN_I);

  assign starve_inc = i_req && !i_flush && !grant_i && (state != BUSY_I);
  assign starve_clr = grant_i || i_flush;

  arb_starve_ctr #(
    .LIM(STARVE_LIM)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .starved(starved)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      i_valid    <= 1'b0;
      i_rdata    <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant && (grant_own == OWN_I)) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
          end else if (grant) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end
        end
        BUSY_I: begin
          if (i_flush) flush_pend <= 1'b1;
          // A flushed fetch still completes on the bus, but its data is dropped.
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            flush_pend <= 1'b0;
            if (!(flush_pend || i_flush)) begin
              i_valid <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_valid <= 1'b1;
            d_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected bus grants and
// responses are queued with their cycle numbers and checked by a monitor.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_XOR = 32'h0050_0083;

  localparam int K_MREQ = 0;
  localparam int K_IV   = 1;
  localparam int K_DV   = 2;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_valid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] data;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   mem_wait = 0;
  logic auto_mem = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: answers after mem_wait cycles of mem_req; data = addr ^ RD_XOR.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mem) begin
        if (mem_req && (wcnt == mem_wait)) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr ^ RD_XOR;
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          if (mem_req) wcnt++;
          else wcnt = 0;
        end
      end
    end
  end

  function automatic string kname(input int k);
    return (k == K_MREQ) ? "mem_req" : (k == K_IV) ? "i_valid" : "d_valid";
  endfunction

  task automatic check_evt(input int kind);
    exp_t e;
    logic ok;
    logic [31:0] act_val;
    checks++;
    act_val = (kind == K_MREQ) ? mem_addr : (kind == K_IV) ? i_rdata : d_rdata;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_%s cyc=%0d got val=%h required no event",
               kname(kind), cyc, act_val);
      return;
    end
    e = sb.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    if (kind == K_MREQ) begin
      ok = ok && (mem_addr == e.addr) && (mem_we == e.we) && (mem_be == e.be);
      if (e.chk) ok = ok && (mem_wdata == e.wdata);
    end else if (e.chk) begin
      ok = ok && (act_val == e.data);
    end
    if (ok) begin
      passes++;
      $display("cyc %0d %s ok val=%h we=%0b be=%h", cyc, kname(kind), act_val,
               mem_we, mem_be);
    end else begin
      $display("FAIL evt_%s got cyc=%0d val=%h we=%0b wd=%h be=%h required %s cyc=%0d addr=%h we=%0b wd=%h be=%h data=%h",
               kname(kind), cyc, act_val, mem_we, mem_wdata, mem_be, kname(e.kind),
               e.cyc, e.addr, e.we, e.wdata, e.be, e.data);
    end
  endtask

  initial begin
    logic mreq_prev;
    mreq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !mreq_prev) check_evt(K_MREQ);
      if (i_valid) check_evt(K_IV);
      if (d_valid) check_evt(K_DV);
      mreq_prev = mem_req;
    end
  end

  task automatic push_mreq(input int c, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    e.kind = K_MREQ; e.cyc = c; e.addr = a; e.we = we; e.wdata = wd; e.be = be;
    e.data = '0; e.chk = we;
    sb.push_back(e);
  endtask

  task automatic push_valid(input int kind, input int c, input logic [31:0] d,
                            input logic chk);
    exp_t e;
    e.kind = kind; e.cyc = c; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.be = '0;
    e.data = d; e.chk = chk;
    sb.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [135:0] act,
                           input logic [135:0] req);
    checks++;
    if (act === req) begin
      passes++;
      $display("cyc %0d %s ok", cyc, name);
    end else begin
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input int target);
    while (cyc < target) tick(1);
  endtask

  function automatic logic [135:0] all_outs();
    return {mem_req, mem_we, mem_addr, mem_wdata, mem_be,
            i_valid, i_rdata, d_valid, d_rdata};
  endfunction

  initial begin
    int c0;
    rst = 1'b1;
    i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    tick(2);
    check_val("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    tick(2);

    // Single fetch, zero-wait memory.
    c0 = cyc;
    i_req = 1; i_addr = 32'h10;
    push_mreq(c0 + 1, 32'h10, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 2, 32'h0050_0093, 1'b1);
    go(c0 + 2); i_req = 0;
    tick(2);

    // Contention: store first, fetch granted in the d_valid cycle.
    c0 = cyc;
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    push_mreq(c0 + 1, 32'h200, 1'b1, 32'hDEAD_BEEF, 4'hF);
    push_valid(K_DV, c0 + 2, '0, 1'b0);
    push_mreq(c0 + 3, 32'h20, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 4, 32'h0050_00A3, 1'b1);
    go(c0 + 2); d_req = 0;
    go(c0 + 4); i_req = 0;
    tick(2);

    // Starvation: fetch waits 4 cycles behind a slow load, then beats data.
    c0 = cyc;
    mem_wait = 3;
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    push_mreq(c0 + 1, 32'h300, 1'b0, '0, 4'hF);
    push_valid(K_DV, c0 + 5, 32'h0050_0383, 1'b1);
    push_mreq(c0 + 7, 32'h50, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 8, 32'h0050_00D3, 1'b1);
    push_mreq(c0 + 9, 32'h304, 1'b0, '0, 4'hF);
    push_valid(K_DV, c0 + 10, 32'h0050_0387, 1'b1);
    go(c0 + 1); i_req = 1; i_addr = 32'h50;
    go(c0 + 5); i_req = 0; d_addr = 32'h304; mem_wait = 0;
    go(c0 + 6); i_req = 1;
    go(c0 + 8); i_req = 0;
    go(c0 + 10); d_req = 0;
    // Counter must have cleared: data wins the next tie.
    go(c0 + 11);
    i_req = 1; i_addr = 32'h60;
    d_req = 1; d_we = 1; d_addr = 32'h308; d_wdata = 32'h1234_5678; d_be = 4'h3;
    push_mreq(c0 + 12, 32'h308, 1'b1, 32'h1234_5678, 4'h3);
    push_valid(K_DV, c0 + 13, '0, 1'b0);
    push_mreq(c0 + 14, 32'h60, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 15, 32'h0050_00E3, 1'b1);
    go(c0 + 13); d_req = 0;
    go(c0 + 15); i_req = 0;
    tick(2);

    // Flush while the fetch is in flight: response dropped, next fetch served.
    c0 = cyc;
    mem_wait = 3;
    i_req = 1; i_addr = 32'h30;
    push_mreq(c0 + 1, 32'h30, 1'b0, '0, 4'hF);
    push_mreq(c0 + 6, 32'h40, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 7, 32'h0050_00C3, 1'b1);
    go(c0 + 2); i_flush = 1; i_req = 0;
    go(c0 + 3); i_flush = 0; i_req = 1; i_addr = 32'h40;
    go(c0 + 5); mem_wait = 0;
    go(c0 + 7); i_req = 0;
    tick(2);

    // Flush in IDLE blocks the grant.
    c0 = cyc;
    i_req = 1; i_addr = 32'h80; i_flush = 1;
    push_mreq(c0 + 3, 32'h84, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 4, 32'h0050_0007, 1'b1);
    go(c0 + 1); i_flush = 0; i_req = 0;
    go(c0 + 2); i_req = 1; i_addr = 32'h84;
    go(c0 + 4); i_req = 0;
    tick(2);

    // Ack masking: new address held through i_valid is granted one cycle later.
    c0 = cyc;
    i_req = 1; i_addr = 32'h70;
    push_mreq(c0 + 1, 32'h70, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 2, 32'h0050_00F3, 1'b1);
    push_mreq(c0 + 4, 32'h74, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 5, 32'h0050_00F7, 1'b1);
    go(c0 + 2); i_addr = 32'h74;
    go(c0 + 5); i_req = 0;
    tick(2);

    // Reset during a store, then a stray mem_ready afterwards.
    auto_mem = 1'b0;
    mem_ready = 1'b0;
    tick(1);
    c0 = cyc;
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'hCAFE_F00D; d_be = 4'hC;
    push_mreq(c0 + 1, 32'h400, 1'b1, 32'hCAFE_F00D, 4'hC);
    go(c0 + 1); rst = 1; d_req = 0;
    go(c0 + 2); rst = 0; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    check_val("reset_mid_access_outputs", all_outs(), '0);
    go(c0 + 3); mem_ready = 0;
    check_val("stray_ready_ignored", {135'd0, d_valid | mem_req}, '0);
    tick(2);
    auto_mem = 1'b1;
    tick(1);

    // FSM back in IDLE: a fetch sees minimum latency.
    c0 = cyc;
    i_req = 1; i_addr = 32'h90;
    push_mreq(c0 + 1, 32'h90, 1'b0, '0, 4'hF);
    push_valid(K_IV, c0 + 2, 32'h0050_0013, 1'b1);
    go(c0 + 2); i_req = 0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    tick(2);
    check_val("scoreboard_drained", {104'd0, 32'(sb.size())}, '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store path of the RV32I core.
- Sits between the PC/fetch stage and the ALU's data-access outputs on one side, and the memory on the other.
- Uses a registered grant FSM with request/valid handshakes.
- Data accesses have priority, with an anti-starvation limit for fetch.
- Supports a fetch flush when a branch is taken.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 wide.
- STARVE_LIM, 4, pending-fetch cycles after which fetch beats data; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_valid.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_flush  in  1  branch taken; cancels the outstanding or pending fetch.
- i_valid  out  1  one-cycle pulse: i_rdata is valid.
- i_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  byte enables.
- d_valid  out  1  one-cycle pulse: access complete; d_rdata is valid for loads.
- d_rdata  out  DW  load data.
- mem_req  out  1  memory access strobe; held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables.
- mem_ready  in  1  one-cycle pulse: access done; mem_rdata is valid.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; starve_cnt = 0; flush_pend = 0.
- Reset mid-access abandons the access. A mem_ready arriving while IDLE is ignored.
- FSM states:
  - IDLE
  - BUSY_I: fetch owns memory.
  - BUSY_D: data owns memory.
- IDLE arbitration, evaluated each cycle:
  - Only d_req: grant data.
  - Only i_req with i_flush=0: grant fetch.
  - Both, starve_cnt < STARVE_LIM: grant data.
  - Both, starve_cnt >= STARVE_LIM: grant fetch.
  - On grant: latch the owner's addr/we/wdata/be into the mem_* registers; mem_req = 1 from the next cycle. Fetch grants drive mem_we = 0 and mem_be = all ones.
- BUSY_x:
  - mem_* outputs are held stable.
  - On mem_ready: mem_req = 0 and mem_rdata is registered into x_rdata.
  - x_valid pulses for exactly one cycle, in the cycle after mem_ready; the FSM is in IDLE during that cycle.
  - Minimum latency: request seen at cycle N, mem_req high at N+1, mem_ready at N+1 (zero-wait memory), x_valid at N+2.
- Ack masking:
  - In the cycle x_valid = 1, that requester's req is ignored by arbitration; the other requester may be granted.
  - The requester drops req, or presents a new address, from the next cycle.
  - Back-to-back accesses by one requester therefore take at least 3 cycles each.
- starve_cnt:
  - Increments, saturating at 15, each cycle i_req=1 and i_flush=0 and fetch is not granted and not in BUSY_I.
  - Clears on fetch grant and on i_flush.
- Flush:
  - i_flush in IDLE or in a grant-pending cycle: the fetch is not granted.
  - i_flush during BUSY_I: sets flush_pend. The memory access runs to completion, but i_valid is suppressed for that response and flush_pend clears.
  - A new i_req may be granted from the cycle after that suppressed response.
  - i_flush never affects data accesses.
- Simultaneous mem_ready and i_flush in BUSY_I: the response is suppressed.
- Stores: d_valid pulses; d_rdata = mem_rdata (don't-care for verification).
- Address and data paths are passed through unmodified: no alignment checks and no width conversion.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, BUSY_I, BUSY_D}.
  - owner encoding {OWN_I, OWN_D}.
  - STARVE_CNT_W = 4.
- One natural sub-module, arb_starve_ctr: the saturating, clearable starvation counter with a >= STARVE_LIM compare output.

Test Plan:
- Single fetch, zero-wait memory: i_req=1, i_addr=0x10 at cycle 0; mem_ready at cycle 1 with mem_rdata=0x00500093 -> mem_req high in cycle 1 with mem_addr=0x10 and mem_we=0; i_valid=1 and i_rdata=0x00500093 at cycle 2.
- Contention: i_req and d_req both raised at cycle 0 (d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=0xF) -> data is served first (mem_we=1, mem_addr=0x200); the fetch is granted in the d_valid cycle and its mem_req rises in the following cycle.
- Starvation, STARVE_LIM=4: d_req held continuously with new accesses each ack, i_req held -> after starve_cnt reaches 4, fetch wins the next IDLE arbitration even though d_req=1, and starve_cnt returns to 0.
- Flush in flight: fetch in BUSY_I with mem_ready delayed by 3 cycles; pulse i_flush in cycle 1 of the wait -> mem_ready is consumed, i_valid stays 0, and the next i_req (i_addr=0x40) is granted afterwards.
- Reset mid-access: assert rst during BUSY_D, then mem_ready arrives after rst is released -> all outputs are 0, FSM is IDLE, the stray mem_ready is ignored, and no d_valid is produced.
- Ack masking: requester keeps i_req=1 through the i_valid cycle with a new address -> no regrant in the i_valid cycle; the new i_addr is granted in the following cycle.
